// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the CU load/store interface and its data memory
// responder.
//   state_t    : responder FSM states (IDLE, BUSY, RESP)
//   LATENCY_*  : legal range of the responder's fixed access latency
//   LAT_CNT_W  : width of the latency down-counter (covers LATENCY_MAX)
//   mem_req_t  : one load/store request {we, addr, wdata} as driven by the CU
// ---------------------------------------------------------------------------
package cu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;
   localparam int LAT_CNT_W   = 4;

   localparam int MEM_ADDR_W  = 6;
   localparam int MEM_DATA_W  = 32;

   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/data_mem_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
// DEPTH x DATA_SIZE storage with a single access port. One access per strobe:
// a store writes the word and clears the read register, a load registers the
// addressed word. Reset clears every word and the read register.
//   clk    in   clock, rising edge
//   rst    in   asynchronous, active-low reset
//   access in   perform the access this cycle (caller guarantees idx < DEPTH)
//   we     in   1 = store, 0 = load
//   idx    in   word index
//   wdata  in   store data
//   rdata  out  registered load data (0 after a store)
// ---------------------------------------------------------------------------
module data_mem_array #(
   parameter int DATA_SIZE = 32,
   parameter int DEPTH     = 32,
   parameter int IDX_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 access,
   input  logic                 we,
   input  logic [IDX_W-1:0]     idx,
   input  logic [DATA_SIZE-1:0] wdata,
   output logic [DATA_SIZE-1:0] rdata
);

   logic [DATA_SIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else if (access) begin
         if (we) begin
            mem[idx] <= wdata;
            rdata    <= '0;
         end else begin
            rdata    <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder side of the CU load/store interface. Accepts one request at a
// time over valid/ready, waits a fixed LATENCY, performs the access on the
// data memory array and presents the result until the CU takes it.
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE and out of reset)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   word address
//   req_wdata  in   store data
//   rsp_valid  out  response present
//   rsp_ready  in   response consumed
//   rsp_rdata  out  load data; 0 for stores and errors
//   rsp_err    out  address out of range, access suppressed
// ---------------------------------------------------------------------------
module data_mem_responder
   import cu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_SIZE     = 32,
   parameter int DEPTH         = 32,
   parameter int LATENCY       = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [ADDRESS_WIDTH:0] req_addr,
   input  logic [DATA_SIZE-1:0]   req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_SIZE-1:0]   rsp_rdata,
   output logic                   rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**(ADDRESS_WIDTH+1) is representable.
   localparam logic [ADDRESS_WIDTH+1:0] DEPTH_LIM = (ADDRESS_WIDTH+2)'(DEPTH);
   localparam logic [LAT_CNT_W-1:0]     LAT_LOAD  = LAT_CNT_W'(LATENCY - 1);

   state_t                 state, state_next;
   logic [LAT_CNT_W-1:0]   lat_cnt;
   logic                   err_q;
   logic                   we_q;
   logic [ADDRESS_WIDTH:0] addr_q;
   logic [DATA_SIZE-1:0]   wdata_q;
   logic [DATA_SIZE-1:0]   arr_rdata;
   logic                   accept;
   logic                   access;
   logic                   in_range;

   // Ready depends on state and reset only, never on req_valid.
   assign req_ready = (state == IDLE) && rst;
   assign accept    = req_valid && req_ready;
   assign access    = (state == BUSY) && (lat_cnt == '0);
   assign in_range  = {1'b0, addr_q} < DEPTH_LIM;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)                 state_next = BUSY;
         BUSY:    if (lat_cnt == '0)          state_next = RESP;
         RESP:    if (rsp_ready)              state_next = IDLE;
         default:                             state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         lat_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            lat_cnt <= LAT_LOAD;
         end else if ((state == BUSY) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (access) begin
            err_q <= !in_range;
         end
      end
   end

   // Request fields are data only: sampled at the accept edge, otherwise held.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   data_mem_array #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk    (clk),
      .rst    (rst),
      .access (access && in_range),
      .we     (we_q),
      .idx    (addr_q[IDX_W-1:0]),
      .wdata  (wdata_q),
      .rdata  (arr_rdata)
   );

   // An out-of-range access leaves the array read register stale; mask it.
   assign rsp_valid = (state == RESP);
   assign rsp_err   = err_q;
   assign rsp_rdata = err_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders (LATENCY=2 and LATENCY=1) driven by directed transactions.
// A request/response model tracks each one and every output is compared on
// every falling edge; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid [2];
   logic        req_we    [2];
   logic [5:0]  req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        rsp_ready [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int n_chk  = 0;
   int n_fail = 0;
   bit armed  = 1'b0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .ADDRESS_WIDTH (5), .DATA_SIZE (32), .DEPTH (32), .LATENCY (2)
   ) dut_l2 (
      .clk (clk), .rst (rst),
      .req_valid (req_valid[0]), .req_ready (req_ready[0]), .req_we (req_we[0]),
      .req_addr (req_addr[0]), .req_wdata (req_wdata[0]),
      .rsp_valid (rsp_valid[0]), .rsp_ready (rsp_ready[0]),
      .rsp_rdata (rsp_rdata[0]), .rsp_err (rsp_err[0])
   );

   data_mem_responder #(
      .ADDRESS_WIDTH (5), .DATA_SIZE (32), .DEPTH (32), .LATENCY (1)
   ) dut_l1 (
      .clk (clk), .rst (rst),
      .req_valid (req_valid[1]), .req_ready (req_ready[1]), .req_we (req_we[1]),
      .req_addr (req_addr[1]), .req_wdata (req_wdata[1]),
      .rsp_valid (rsp_valid[1]), .rsp_ready (rsp_ready[1]),
      .rsp_rdata (rsp_rdata[1]), .rsp_err (rsp_err[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // ph: 0 waiting for a request, 1 request outstanding, 2 response shown
   int          lat_of [2] = '{2, 1};
   int          cyc = 0;
   int          ph      [2];
   int          due     [2];
   logic        p_we    [2];
   logic [5:0]  p_addr  [2];
   logic [31:0] p_wdata [2];
   logic [31:0] o_rd    [2];
   logic        o_err   [2];
   logic [31:0] mm      [2][32];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            ph[i] = 0; o_rd[i] = '0; o_err[i] = 1'b0;
            for (int j = 0; j < 32; j++) mm[i][j] = '0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            case (ph[i])
               0: if (req_valid[i] === 1'b1) begin
                     p_we[i] = req_we[i]; p_addr[i] = req_addr[i]; p_wdata[i] = req_wdata[i];
                     due[i] = cyc + lat_of[i];
                     ph[i] = 1;
                  end
               1: if (cyc == due[i]) begin
                     if (p_addr[i] >= 6'd32) begin
                        o_err[i] = 1'b1; o_rd[i] = '0;
                     end else if (p_we[i]) begin
                        mm[i][p_addr[i][4:0]] = p_wdata[i];
                        o_err[i] = 1'b0; o_rd[i] = '0;
                     end else begin
                        o_err[i] = 1'b0; o_rd[i] = mm[i][p_addr[i][4:0]];
                     end
                     ph[i] = 2;
                  end
               default: if (rsp_ready[i] === 1'b1) ph[i] = 0;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("model req_ready[%0d]", i), 32'(req_ready[i]), 32'(rst && (ph[i] == 0)));
            check($sformatf("model rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(ph[i] == 2));
            check($sformatf("model rsp_rdata[%0d]", i), rsp_rdata[i], o_rd[i]);
            check($sformatf("model rsp_err[%0d]", i), 32'(rsp_err[i]), 32'(o_err[i]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // All helpers start and (except wait_rsp) end 1 time unit after a rising edge.
   task automatic issue(input int i, input logic we, input logic [5:0] a,
                        input logic [31:0] d, input bit keep, output int acc);
      bit got = 1'b0;
      req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = req_ready[i];
         @(posedge clk); #1;
      end
      acc = cyc;
      check("accept", 32'(got), 32'd1);
      if (!keep) req_valid[i] = 1'b0;
   endtask

   // Returns on the falling edge where rsp_valid is first seen.
   task automatic wait_rsp(input int i, output int edges);
      bit seen = 1'b0;
      edges = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = rsp_valid[i];
         if (!seen) begin
            @(posedge clk); #1;
            edges++;
         end
      end
      check("rsp_valid seen", 32'(seen), 32'd1);
   endtask

   task automatic xact(input int i, input logic we, input logic [5:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int edges, output int acc);
      issue(i, we, a, d, 1'b0, acc);
      wait_rsp(i, edges);
      rd = rsp_rdata[i];
      er = rsp_err[i];
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd, held;
      logic        er;
      int          edges, acc, prev;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
         req_wdata[i] = '0;   rsp_ready[i] = 1'b1;
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 armed = 1'b1;

      // Reset state
      @(negedge clk);
      check("reset req_ready", 32'(req_ready[0]), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("reset rsp_rdata", rsp_rdata[0], 32'd0);
      check("reset rsp_err",   32'(rsp_err[0]),   32'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("idle req_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;

      // Store then load @5, LATENCY=2
      xact(0, 1'b1, 6'd5, 32'hDEADBEEF, rd, er, edges, acc);
      check("store latency", 32'(edges), 32'd2);
      check("store rdata", rd, 32'd0);
      check("store err", 32'(er), 32'd0);
      xact(0, 1'b0, 6'd5, 32'd0, rd, er, edges, acc);
      check("load latency", 32'(edges), 32'd2);
      check("load rdata", rd, 32'hDEADBEEF);

      // Backpressure on a load @5
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, 6'd5, 32'd0, 1'b0, acc);
      wait_rsp(0, edges);
      held = rsp_rdata[0];
      check("bp first rdata", held, 32'hDEADBEEF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
         check("bp rdata stable", rsp_rdata[0], 32'hDEADBEEF);
         check("bp req_ready", 32'(req_ready[0]), 32'd0);
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp released idle", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;

      // Out of range store @40, then load @8
      xact(0, 1'b1, 6'd40, 32'h1234, rd, er, edges, acc);
      check("oor err", 32'(er), 32'd1);
      check("oor rdata", rd, 32'd0);
      check("oor latency", 32'(edges), 32'd2);
      xact(0, 1'b0, 6'd8, 32'd0, rd, er, edges, acc);
      check("load @8 rdata", rd, 32'd0);
      check("load @8 err", 32'(er), 32'd0);

      // Request held valid with changing fields during BUSY
      issue(0, 1'b1, 6'd9, 32'h11, 1'b1, acc);
      req_addr[0] = 6'd10; req_wdata[0] = 32'h22;
      wait_rsp(0, edges);
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      xact(0, 1'b0, 6'd9, 32'd0, rd, er, edges, acc);
      check("held load @9", rd, 32'h11);
      xact(0, 1'b0, 6'd10, 32'd0, rd, er, edges, acc);
      check("held load @10", rd, 32'd0);

      // Reset in the middle of a store's BUSY phase
      issue(0, 1'b1, 6'd3, 32'hAA, 1'b0, acc);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      check("mid-reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("mid-reset req_ready", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      xact(0, 1'b0, 6'd3, 32'd0, rd, er, edges, acc);
      check("post-reset load @3", rd, 32'd0);
      xact(0, 1'b0, 6'd5, 32'd0, rd, er, edges, acc);
      check("post-reset load @5", rd, 32'd0);

      // LATENCY=1 alternating stores/loads @0..7
      prev = -1;
      for (int k = 0; k < 8; k++) begin
         xact(1, 1'b1, 6'(k), 32'hA5000000 + 32'(k) * 32'h111, rd, er, edges, acc);
         check("l1 store latency", 32'(edges), 32'd1);
         if (prev >= 0) check("l1 spacing", 32'(acc - prev), 32'd3);
         prev = acc;
         xact(1, 1'b0, 6'(k), 32'd0, rd, er, edges, acc);
         check("l1 load latency", 32'(edges), 32'd1);
         check("l1 spacing", 32'(acc - prev), 32'd3);
         check("l1 load rdata", rd, 32'hA5000000 + 32'(k) * 32'h111);
         prev = acc;
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
